// File: rtl/os_inst_sequencer.sv
// Output-stationary instruction sequencer for core: walks every input channel through
// L0/L1 fill, compute and flush, then recalls psums and drains the OFIFO into PSUM SRAM.
module os_inst_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int n_ic    = 8,
    parameter int x_base  = 0,
    parameter int w_base  = 576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] LEN_C       = CNT_W'(len_kij);
    localparam logic [CNT_W-1:0] EXEC_LAST   = CNT_W'(len_kij - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(row + col - 1);
    localparam logic [CNT_W-1:0] COL_C       = CNT_W'(col);
    localparam logic [7:0]       IC_LAST     = 8'(n_ic - 1);
    localparam logic [10:0]      X_BASE_C    = 11'(x_base);
    localparam logic [10:0]      W_BASE_C    = 11'(w_base);
    localparam logic [10:0]      LEN_A       = 11'(len_kij);

    // output_stationary, CEN_pmem, WEN_pmem, CEN_xmem, WEN_xmem
    localparam logic [63:0] IDLE_WORD = 64'h0000_0011_800C_0000;
    // pass_psum, sfu_passthrough, ofifo_rd
    localparam logic [63:0] RD_BITS   = (64'd1 << 39) | (64'd1 << 34) | (64'd1 << 6);

    typedef enum logic [3:0] {
        S_IDLE,
        S_L0_FILL,
        S_L1_FILL,
        S_PRIME,
        S_EXEC,
        S_FLUSH,
        S_RECALL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] beat_q, beat_n;
    logic [7:0]       ic_q, ic_n;
    logic [63:0]      word_q, word_n;
    logic             rd_window_q, rd_window_n;
    logic             wr_n;
    logic             busy_n, done_n;
    logic             rd_fire;

    function automatic logic [10:0] xmem_addr(input logic [10:0] base,
                                              input logic [7:0] ic,
                                              input logic [CNT_W-1:0] k);
        return base + 11'(ic) * LEN_A + 11'(k);
    endfunction

    // Instruction word for the cycle described by the given (next) state and counters.
    function automatic logic [63:0] make_word(input state_t s,
                                              input logic [7:0] ic,
                                              input logic [CNT_W-1:0] cnt,
                                              input logic [CNT_W-1:0] beat,
                                              input logic wr);
        logic [63:0] w;
        w = IDLE_WORD;
        case (s)
            S_L0_FILL, S_L1_FILL: begin
                if (cnt < LEN_C) begin
                    w[19]   = 1'b0;
                    w[17:7] = xmem_addr((s == S_L1_FILL) ? W_BASE_C : X_BASE_C, ic, cnt);
                end
                if (cnt != '0) begin
                    if (s == S_L0_FILL) w[2] = 1'b1;
                    else                w[37] = 1'b1;
                end
            end
            S_PRIME: w[3] = 1'b1;
            S_EXEC: begin
                w[3] = 1'b1;
                w[1] = 1'b1;
            end
            S_RECALL: begin
                w[38] = 1'b1;
                w[34] = 1'b1;
            end
            S_DRAIN: begin
                if (wr) begin
                    w[32]    = 1'b0;
                    w[31]    = 1'b0;
                    w[30:20] = 11'(COL_C - beat);
                end
            end
            default: ;
        endcase
        return w;
    endfunction

    // The read strobe is qualified by ofifo_valid in the same cycle so it never fires
    // against an empty OFIFO; the pmem write that follows it is registered.
    assign rd_fire = rd_window_q & ofifo_valid;
    assign inst    = word_q | (rd_fire ? RD_BITS : 64'd0);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        beat_n  = beat_q;
        ic_n    = ic_q;
        wr_n    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_L0_FILL;
                    cnt_n   = '0;
                    ic_n    = '0;
                    beat_n  = '0;
                end
            end
            S_L0_FILL: begin
                if (cnt_q == LEN_C) begin
                    state_n = S_L1_FILL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_L1_FILL: begin
                if (cnt_q == LEN_C) begin
                    state_n = S_PRIME;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_PRIME: begin
                state_n = S_EXEC;
                cnt_n   = '0;
            end
            S_EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    state_n = S_FLUSH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_n = '0;
                    if (ic_q == IC_LAST) begin
                        state_n = S_RECALL;
                    end else begin
                        state_n = S_L0_FILL;
                        ic_n    = ic_q + 8'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_RECALL: begin
                state_n = S_DRAIN;
                beat_n  = '0;
            end
            S_DRAIN: begin
                if (rd_fire) begin
                    beat_n = beat_q + 1'b1;
                    wr_n   = 1'b1;
                end
                // beat reaches col only on the last read, so its write is on inst now
                if (beat_q == COL_C) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        word_n      = make_word(state_n, ic_n, cnt_n, beat_n, wr_n);
        rd_window_n = (state_n == S_DRAIN) && (beat_n < COL_C);
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            ic_q        <= '0;
            word_q      <= IDLE_WORD;
            rd_window_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            beat_q      <= beat_n;
            ic_q        <= ic_n;
            word_q      <= word_n;
            rd_window_q <= rd_window_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_os_inst_sequencer.sv
// Directed bench for os_inst_sequencer: idle/reset word, full run, drain order, stall, mid-run reset.
module tb_os_inst_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [63:0] inst;
    logic        busy;
    logic        done;

    os_inst_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] IDLE_W = 64'h0000_0011_800C_0000;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] w_log [0:449];
    logic        b_log [0:449];
    logic        d_log [0:449];
    logic        v_log [0:449];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with the DUT idle; cycle c is the c-th cycle after the start edge.
    task automatic run_seq(input int ncyc, input int lo, input int hi, input int sa, input int sb);
        start       = 1'b1;
        ofifo_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            ofifo_valid = (c >= lo && c <= hi) ? 1'b0 : 1'b1;
            start       = (c == sa || c == sb);
            #1;
            w_log[c] = inst;
            b_log[c] = busy;
            d_log[c] = done;
            v_log[c] = ofifo_valid;
            @(negedge clk);
        end
        start       = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    function automatic int cnt_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (w_log[c][b] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_done(input int hi);
        int n = 0;
        for (int c = 1; c <= hi; c++) if (d_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int rd_while_invalid(input int hi);
        int n = 0;
        for (int c = 1; c <= hi; c++) if (w_log[c][6] === 1'b1 && v_log[c] !== 1'b1) n++;
        return n;
    endfunction

    initial begin
        int bad;
        int c0;
        int rc;
        reset       = 1'b0;
        start       = 1'b0;
        ofifo_valid = 1'b1;

        // reset and idle
        repeat (3) @(negedge clk);
        #1;
        chk("rst_inst", inst, IDLE_W);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        bad   = 0;
        repeat (100) begin
            @(negedge clk);
            if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_100", 64'(bad), 64'd0);

        // full run, ofifo_valid high, stray start pulses at 50 and 300
        run_seq(400, 0, -1, 50, 300);
        chk("c1_word", w_log[1], 64'h0000_0011_8004_0000);
        chk("c1_busy", 64'(b_log[1]), 64'd1);
        for (int ic = 0; ic < 8; ic += 7) begin
            c0 = ic * 46 + 1;
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("l0_ic%0d_k%0d", ic, k), {52'd0, w_log[c0 + k][19], w_log[c0 + k][17:7]},
                    {52'd0, 1'b0, 11'(ic * 9 + k)});
                chk($sformatf("l1_ic%0d_k%0d", ic, k), {52'd0, w_log[c0 + 10 + k][19], w_log[c0 + 10 + k][17:7]},
                    {52'd0, 1'b0, 11'(576 + ic * 9 + k)});
            end
            chk($sformatf("l0_tail_ic%0d", ic), {62'd0, w_log[c0 + 9][19], w_log[c0 + 9][2]}, 64'd3);
        end
        for (int ic = 0; ic < 8; ic++) begin
            c0 = ic * 46 + 1;
            chk($sformatf("exec_cnt_ic%0d", ic), 64'(cnt_bit(1, c0, c0 + 45)), 64'd9);
            chk($sformatf("l0rd_cnt_ic%0d", ic), 64'(cnt_bit(3, c0, c0 + 45)), 64'd10);
            chk($sformatf("l0wr_cnt_ic%0d", ic), 64'(cnt_bit(2, c0, c0 + 45)), 64'd9);
            chk($sformatf("l1wr_cnt_ic%0d", ic), 64'(cnt_bit(37, c0, c0 + 45)), 64'd9);
        end
        chk("prime_word", w_log[21], 64'h0000_0011_800C_0008);
        chk("exec_word",  w_log[22], 64'h0000_0011_800C_000A);
        chk("flush_word", w_log[31], IDLE_W);
        chk("recall_word", w_log[369], 64'h0000_0055_800C_0000);
        chk("drain_first", w_log[370], 64'h0000_0095_800C_0040);
        chk("drain_second", w_log[371], 64'h0000_0094_007C_0040);
        chk("drain_tail", w_log[378], 64'h0000_0010_000C_0000);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rd%0d", i), {62'd0, w_log[370 + i][39], w_log[370 + i][6]}, 64'd3);
            chk($sformatf("wr%0d", i), {51'd0, w_log[371 + i][32], w_log[371 + i][31], w_log[371 + i][30:20]},
                {51'd0, 2'b00, 11'(7 - i)});
        end
        chk("pass_psum_total", 64'(cnt_bit(39, 1, 400)), 64'd8);
        chk("ofifo_rd_total", 64'(cnt_bit(6, 1, 400)), 64'd8);
        chk("done_378", 64'(d_log[378]), 64'd0);
        chk("done_379", 64'(d_log[379]), 64'd1);
        chk("busy_379", 64'(b_log[379]), 64'd1);
        chk("busy_380", 64'(b_log[380]), 64'd0);
        chk("done_pulses", 64'(cnt_done(400)), 64'd1);

        // stall: ofifo_valid low for 3 cycles after the 4th read
        run_seq(400, 374, 376, 0, 0);
        for (int i = 0; i < 8; i++) begin
            rc = (i < 4) ? 370 + i : 373 + i;
            chk($sformatf("st_rd%0d", i), 64'(w_log[rc][6]), 64'd1);
            chk($sformatf("st_wr%0d", i), {51'd0, w_log[rc + 1][32], w_log[rc + 1][31], w_log[rc + 1][30:20]},
                {51'd0, 2'b00, 11'(7 - i)});
        end
        chk("st_rd_invalid", 64'(rd_while_invalid(400)), 64'd0);
        chk("st_rd_total", 64'(cnt_bit(6, 1, 400)), 64'd8);
        chk("st_done_381", 64'(d_log[381]), 64'd0);
        chk("st_done_382", 64'(d_log[382]), 64'd1);
        chk("st_done_pulses", 64'(cnt_done(400)), 64'd1);

        // asynchronous reset in the middle of a run, then replay from ic=0
        run_seq(199, 0, -1, 0, 0);
        #1;
        chk("pre_rst_axmem", 64'(inst[17:7]), 64'd617);
        reset = 1'b0;
        #1;
        chk("mid_rst_inst", inst, IDLE_W);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", inst, IDLE_W);
        run_seq(3, 0, -1, 0, 0);
        chk("replay_c1", {52'd0, w_log[1][19], w_log[1][17:7]}, 64'd0);
        chk("replay_c2", {52'd0, w_log[2][19], w_log[2][17:7]}, 64'd1);
        chk("replay_c2_l0wr", 64'(w_log[2][2]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
